// File: rtl/level_timer.sv
// rtl/level_timer.sv - per-level countdown timer with binary and BCD time left
// Loads a level budget on start_level, counts whole seconds down and pulses level_ended once per level.
module level_timer #(
  parameter int unsigned CLK_FREQ  = 31_500_000,
  parameter logic [7:0]  MAX_TIME  = 8'd99,
  parameter logic [7:0]  WARN_SECS = 8'd10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_level,
  input  logic [7:0] timer_time,
  input  logic       pause,
  input  logic       all_collected,
  output logic       level_ended,
  output logic [7:0] time_left,
  output logic [3:0] time_tens,
  output logic [3:0] time_units,
  output logic       running,
  output logic       warning,
  output logic       sec_tick
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    left_q, left_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          ended_q, ended_d;
  logic          running_q, running_d;

  logic [7:0]    load_val;
  logic [7:0]    load_rem;
  logic [3:0]    load_tens;
  logic          tick;

  // Saturate the budget and split it into digits by repeated subtraction of ten.
  always_comb begin
    load_val  = (timer_time > MAX_TIME) ? MAX_TIME : timer_time;
    load_rem  = load_val;
    load_tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (load_rem >= 8'd10) begin
        load_rem  = load_rem - 8'd10;
        load_tens = load_tens + 4'd1;
      end
    end
  end

  // A tick only counts when nothing of higher priority claims the cycle.
  assign tick = (state_q == S_RUN) && !start_level && !all_collected && !pause &&
                (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    left_d  = left_q;
    tens_d  = tens_q;
    units_d = units_q;
    ended_d = 1'b0;
    if (start_level) begin
      left_d  = load_val;
      tens_d  = load_tens;
      units_d = load_rem[3:0];
      presc_d = '0;
      if (load_val == 8'd0) begin
        state_d = S_DONE;
        ended_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (all_collected) begin
            state_d = S_DONE;
            ended_d = 1'b1;
          end else if (!pause) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              if (left_q != 8'd0) begin
                left_d = left_q - 8'd1;
                if (units_q == 4'd0) begin
                  units_d = 4'd9;
                  tens_d  = tens_q - 4'd1;
                end else begin
                  units_d = units_q - 4'd1;
                end
              end
              if (left_q <= 8'd1) begin
                state_d = S_DONE;
                ended_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      left_q    <= 8'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      ended_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      left_q    <= left_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      ended_q   <= ended_d;
      running_q <= running_d;
    end
  end

  assign level_ended = ended_q;
  assign time_left   = left_q;
  assign time_tens   = tens_q;
  assign time_units  = units_q;
  assign running     = running_q;
  assign warning     = (state_q == S_RUN) && (left_q != 8'd0) && (left_q <= WARN_SECS);
  assign sec_tick    = tick;

endmodule

// File: tb/tb_level_timer.sv
// tb/tb_level_timer.sv - scoreboard bench for level_timer against a seconds-arithmetic model
module tb_level_timer;

  localparam int CF   = 10;
  localparam int WARN = 10;
  localparam int MAXT = 99;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start_level = 1'b0;
  logic [7:0] timer_time = 8'd0;
  logic       pause = 1'b0;
  logic       all_collected = 1'b0;
  logic       level_ended;
  logic [7:0] time_left;
  logic [3:0] time_tens;
  logic [3:0] time_units;
  logic       running;
  logic       warning;
  logic       sec_tick;

  level_timer #(.CLK_FREQ(CF), .MAX_TIME(8'd99), .WARN_SECS(8'd10)) dut (
    .clk(clk), .resetN(resetN), .start_level(start_level), .timer_time(timer_time),
    .pause(pause), .all_collected(all_collected), .level_ended(level_ended),
    .time_left(time_left), .time_tens(time_tens), .time_units(time_units),
    .running(running), .warning(warning), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ended;
    int tick;
    int left;
    int tens;
    int units;
    int run;
    int warn;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: 0 idle, 1 run, 2 done; time left derived from active cycles since load
  int m_state, m_n, m_active, m_left, m_ended;

  function automatic void chk(string name, int c, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_n = 0; m_active = 0; m_left = 0; m_ended = 0;
  endfunction

  function automatic void model_cycle(int s, int t, int p, int a);
    exp_t e;
    e.cyc   = cyc;
    e.ended = m_ended;
    e.tick  = (m_state == 1 && s == 0 && a == 0 && p == 0 && ((m_active + 1) % CF) == 0) ? 1 : 0;
    e.left  = m_left;
    e.tens  = m_left / 10;
    e.units = m_left % 10;
    e.run   = (m_state == 1) ? 1 : 0;
    e.warn  = (m_state == 1 && m_left > 0 && m_left <= WARN) ? 1 : 0;
    exp_q.push_back(e);
    m_ended = 0;
    if (s != 0) begin
      m_n      = (t > MAXT) ? MAXT : t;
      m_left   = m_n;
      m_active = 0;
      m_state  = (m_n == 0) ? 2 : 1;
      m_ended  = (m_n == 0) ? 1 : 0;
    end else if (m_state == 1 && a != 0) begin
      m_state = 2;
      m_ended = 1;
    end else if (m_state == 1 && p == 0) begin
      m_active++;
      m_left = m_n - m_active / CF;
      if (m_left == 0) begin
        m_state = 2;
        m_ended = 1;
      end
    end
    cyc++;
  endfunction

  task automatic step(int s, int t, int p, int a);
    @(posedge clk);
    #1;
    start_level   = s[0];
    timer_time    = t[7:0];
    pause         = p[0];
    all_collected = a[0];
    model_cycle(s, t, p, a);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("level_ended", e.cyc, int'(level_ended), e.ended);
      chk("sec_tick",    e.cyc, int'(sec_tick),    e.tick);
      chk("time_left",   e.cyc, int'(time_left),   e.left);
      chk("time_tens",   e.cyc, int'(time_tens),   e.tens);
      chk("time_units",  e.cyc, int'(time_units),  e.units);
      chk("running",     e.cyc, int'(running),     e.run);
      chk("warning",     e.cyc, int'(warning),     e.warn);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p_lvl;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // idle after reset, then a 3 s level running to timeout
    step(0, 0, 0, 0);
    step(1, 3, 0, 0);
    repeat (34) step(0, 0, 0, 0);

    // saturating load and BCD borrow across 90 -> 89
    step(1, 150, 0, 0);
    repeat (105) step(0, 0, 0, 0);

    // pause preserves the fraction of a second
    step(1, 5, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (25) step(0, 0, 1, 0);
    repeat (12) step(0, 0, 0, 0);

    // early clear on a tick cycle, held high afterwards
    step(1, 20, 0, 0);
    for (int i = 0; i < 200 && m_active != 89; i++) step(0, 0, 0, 0);
    chk("reach_tick_at_12", cyc, m_active, 89);
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // zero load, then restart
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 4, 0, 0);
    repeat (12) step(0, 0, 0, 0);

    // warning window, restart mid-run, async reset mid-count
    step(1, 12, 0, 0);
    for (int i = 0; i < 200 && m_left != 3; i++) step(0, 0, 0, 0);
    step(1, 8, 0, 0);
    repeat (15) step(0, 0, 0, 0);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("rst_time_left",   cyc, int'(time_left),   0);
    chk("rst_time_tens",   cyc, int'(time_tens),   0);
    chk("rst_time_units",  cyc, int'(time_units),  0);
    chk("rst_running",     cyc, int'(running),     0);
    chk("rst_warning",     cyc, int'(warning),     0);
    chk("rst_level_ended", cyc, int'(level_ended), 0);
    chk("rst_sec_tick",    cyc, int'(sec_tick),    0);
    model_reset();
    @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    // randomized traffic
    p_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      int s, t, a;
      if ($urandom_range(0, 9) == 0) p_lvl = 1 - p_lvl;
      s = (m_state == 1) ? (($urandom_range(0, 79) == 0) ? 1 : 0)
                         : (($urandom_range(0, 9) == 0) ? 1 : 0);
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      a = ($urandom_range(0, 99) < 2) ? 1 : 0;
      step(s, t, p_lvl, a);
    end

    @(posedge clk);
    #1 start_level = 1'b0; pause = 1'b0; all_collected = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
